// File: rtl/axi_rd_arbiter_2to1.sv
// Two AXI3 read masters (m0 dcache, m1 icache) onto one slave read port, one burst in flight; AR accepted at N, on the bus at N+1.
// R beats forwarded combinationally to the latched grant; the granted master's rready stalls the bus directly, nothing is buffered.
module axi_rd_arbiter_2to1 #(
    parameter bit RR_EN = 1'b1,
    parameter int ID_W  = 4
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] m0_arid,
    input  logic [31:0]     m0_araddr,
    input  logic [3:0]      m0_arlen,
    input  logic [2:0]      m0_arsize,
    input  logic [1:0]      m0_arburst,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [ID_W-1:0] m0_rid,
    output logic [31:0]     m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rlast,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    input  logic [ID_W-1:0] m1_arid,
    input  logic [31:0]     m1_araddr,
    input  logic [3:0]      m1_arlen,
    input  logic [2:0]      m1_arsize,
    input  logic [1:0]      m1_arburst,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [ID_W-1:0] m1_rid,
    output logic [31:0]     m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rlast,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    output logic [ID_W-1:0] s_arid,
    output logic [31:0]     s_araddr,
    output logic [3:0]      s_arlen,
    output logic [2:0]      s_arsize,
    output logic [1:0]      s_arburst,
    output logic [1:0]      s_arlock,
    output logic [3:0]      s_arcache,
    output logic [2:0]      s_arprot,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [ID_W-1:0] s_rid,
    input  logic [31:0]     s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rlast,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic            busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            gnt_q, gnt_d;
    logic [ID_W-1:0] arid_q, arid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [3:0]      arlen_q, arlen_d;
    logic [2:0]      arsize_q, arsize_d;
    logic [1:0]      arburst_q, arburst_d;

    logic is_idle, is_addr, is_data, pick1, ar_hs, r_done, route0, route1;

    assign is_idle = (state_q == IDLE);
    assign is_addr = (state_q == ADDR);
    assign is_data = (state_q == DATA);

    // m1 wins when alone, or on contention when round-robin says m0 had the last turn
    assign pick1 = m1_arvalid & (~m0_arvalid | (RR_EN & ~last_grant_q));
    assign ar_hs = is_idle & (m0_arvalid | m1_arvalid);

    assign m0_arready = is_idle & m0_arvalid & ~pick1;
    assign m1_arready = is_idle & pick1;

    assign s_arvalid = is_addr;
    assign s_arid    = arid_q;
    assign s_araddr  = araddr_q;
    assign s_arlen   = arlen_q;
    assign s_arsize  = arsize_q;
    assign s_arburst = arburst_q;
    assign s_arlock  = '0;
    assign s_arcache = '0;
    assign s_arprot  = '0;

    // Routing follows the latched grant only; rid is passed through, never decoded
    assign route0   = is_data & ~gnt_q;
    assign route1   = is_data & gnt_q;
    assign s_rready = (route0 & m0_rready) | (route1 & m1_rready);
    assign r_done   = is_data & s_rvalid & s_rready & s_rlast;

    assign m0_rvalid = route0 & s_rvalid;
    assign m0_rid    = route0 ? s_rid   : '0;
    assign m0_rdata  = route0 ? s_rdata : '0;
    assign m0_rresp  = route0 ? s_rresp : '0;
    assign m0_rlast  = route0 & s_rlast;
    assign m1_rvalid = route1 & s_rvalid;
    assign m1_rid    = route1 ? s_rid   : '0;
    assign m1_rdata  = route1 ? s_rdata : '0;
    assign m1_rresp  = route1 ? s_rresp : '0;
    assign m1_rlast  = route1 & s_rlast;

    assign busy = ~is_idle;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d      = ADDR;
                    gnt_d        = pick1;
                    last_grant_d = pick1;
                    arid_d       = pick1 ? m1_arid    : m0_arid;
                    araddr_d     = pick1 ? m1_araddr  : m0_araddr;
                    arlen_d      = pick1 ? m1_arlen   : m0_arlen;
                    arsize_d     = pick1 ? m1_arsize  : m0_arsize;
                    arburst_d    = pick1 ? m1_arburst : m0_arburst;
                end
            end
            ADDR:    if (s_arready) state_d = DATA;
            DATA:    if (r_done)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Bench for axi_rd_arbiter_2to1: a round-robin instance and a fixed-priority instance share every input.
module tb_axi_rd_arbiter_2to1;
    localparam int ID_W = 4;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic aresetn;

    logic [ID_W-1:0] m0_arid, m1_arid, s_rid;
    logic [31:0]     m0_araddr, m1_araddr, s_rdata;
    logic [3:0]      m0_arlen, m1_arlen;
    logic [2:0]      m0_arsize, m1_arsize;
    logic [1:0]      m0_arburst, m1_arburst, s_rresp;
    logic            m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic            s_arready, s_rlast, s_rvalid;

    logic            m0_arready, m1_arready, m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
    logic [ID_W-1:0] m0_rid, m1_rid, s_arid;
    logic [31:0]     m0_rdata, m1_rdata, s_araddr;
    logic [1:0]      m0_rresp, m1_rresp, s_arburst, s_arlock;
    logic [3:0]      s_arlen, s_arcache;
    logic [2:0]      s_arsize, s_arprot;
    logic            s_arvalid, s_rready, busy;

    logic            f_m0_arready, f_m1_arready, f_m0_rlast, f_m1_rlast, f_m0_rvalid, f_m1_rvalid;
    logic [ID_W-1:0] f_m0_rid, f_m1_rid, f_s_arid;
    logic [31:0]     f_m0_rdata, f_m1_rdata, f_s_araddr;
    logic [1:0]      f_m0_rresp, f_m1_rresp, f_s_arburst, f_s_arlock;
    logic [3:0]      f_s_arlen, f_s_arcache;
    logic [2:0]      f_s_arsize, f_s_arprot;
    logic            f_s_arvalid, f_s_rready, f_busy;

    axi_rd_arbiter_2to1 #(.RR_EN(1'b1), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .busy(busy)
    );

    axi_rd_arbiter_2to1 #(.RR_EN(1'b0), .ID_W(ID_W)) dut_fp (
        .aclk(aclk), .aresetn(aresetn),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
        .m0_rid(f_m0_rid), .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rlast(f_m0_rlast),
        .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
        .m1_rid(f_m1_rid), .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rlast(f_m1_rlast),
        .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
        .s_arid(f_s_arid), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize),
        .s_arburst(f_s_arburst), .s_arlock(f_s_arlock), .s_arcache(f_s_arcache), .s_arprot(f_s_arprot),
        .s_arvalid(f_s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(f_s_rready), .busy(f_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 1'b0;
        #2;
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_arready", {m0_arready, m1_arready}, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_held_ar", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, 0);
        step();
        step();
        aresetn = 1'b1;
    endtask

    // Called in ADDR: accepts the AR, then delivers one last beat; g / fg = expected owner in each instance.
    task automatic serve1(input logic [ID_W-1:0] exp_id, input logic [31:0] dat, input int g, input int fg);
        s_arready = 1'b1;
        @(negedge aclk);
        chk("srv_s_arvalid", s_arvalid, 1);
        chk("srv_s_arid", s_arid, exp_id);
        chk("srv_arready_addr", {m0_arready, m1_arready}, 0);
        step();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = dat; s_rid = exp_id;
        m0_rready = 1'b1; m1_rready = 1'b1;
        @(negedge aclk);
        chk("srv_rr_rvalid", {m1_rvalid, m0_rvalid}, (g == 1) ? 2'b10 : 2'b01);
        chk("srv_fp_rvalid", {f_m1_rvalid, f_m0_rvalid}, (fg == 1) ? 2'b10 : 2'b01);
        chk("srv_rdata", (g == 1) ? m1_rdata : m0_rdata, dat);
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    typedef struct packed {
        logic v0, v1, srv, rr0, rr1;
        logic e_ar0, e_ar1, e_srr, e_rv0, e_rv1;
    } vec_t;
    vec_t tbl[7];

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [3:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } ar_t;

    initial begin
        int beat;
        int ph, own, lastw, w, beats_left;
        bit any, sl_taken, e_srr;
        ar_t held;

        // Fresh out of reset, idle: m0 wins contention in both instances; stray s_rvalid goes nowhere
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        do_reset();
        step();
        for (int i = 0; i < 7; i++) begin
            m0_arvalid = tbl[i].v0; m1_arvalid = tbl[i].v1; s_rvalid = tbl[i].srv; s_rlast = tbl[i].srv;
            m0_rready = tbl[i].rr0; m1_rready = tbl[i].rr1;
            @(negedge aclk);
            chk($sformatf("tbl%0d_arready", i), {m0_arready, m1_arready}, {tbl[i].e_ar0, tbl[i].e_ar1});
            chk($sformatf("tbl%0d_fp_arready", i), {f_m0_arready, f_m1_arready}, {tbl[i].e_ar0, tbl[i].e_ar1});
            chk($sformatf("tbl%0d_s_rready", i), s_rready, tbl[i].e_srr);
            chk($sformatf("tbl%0d_rvalid", i), {m0_rvalid, m1_rvalid}, {tbl[i].e_rv0, tbl[i].e_rv1});
            chk($sformatf("tbl%0d_busy", i), {busy, s_arvalid}, 0);
            m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
            step();
        end

        // Single m0 read with s_arready held off two cycles
        m0_arid = 4'h5; m0_araddr = 32'h1FC0_0000; m0_arlen = 4'd0; m0_arsize = 3'd2; m0_arburst = 2'b01;
        m0_arvalid = 1'b1;
        @(negedge aclk);
        chk("t1_arready_c0", {m0_arready, m1_arready}, 2'b10);
        chk("t1_s_arvalid_c0", s_arvalid, 0);
        step();
        m0_arvalid = 1'b0; m0_araddr = 32'hDEAD_BEEF; m0_arid = 4'hA;
        for (int c = 1; c <= 3; c++) begin
            s_arready = (c == 3);
            @(negedge aclk);
            chk($sformatf("t1_s_arvalid_c%0d", c), s_arvalid, 1);
            chk($sformatf("t1_s_ar_c%0d", c), {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                {4'h5, 32'h1FC0_0000, 4'd0, 3'd2, 2'b01});
            step();
        end
        chk("t1_s_ar_consts", {s_arlock, s_arcache, s_arprot}, 0);
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h3C08_0000; s_rid = 4'h5; s_rresp = 2'b00; s_rlast = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        @(negedge aclk);
        chk("t1_m0_beat", {m0_rvalid, m0_rdata, m0_rid, m0_rlast}, {1'b1, 32'h3C08_0000, 4'h5, 1'b1});
        chk("t1_m1_rvalid", m1_rvalid, 0);
        chk("t1_s_rready", s_rready, 1);
        step();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge aclk);
        chk("t1_busy_after", busy, 0);
        step();

        // Continuous contention: round-robin alternates m0,m1,...; fixed priority always m0
        do_reset();
        m0_arid = 4'h1; m0_araddr = 32'h0000_1000; m1_arid = 4'h2; m1_araddr = 32'h0000_2000;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge aclk);
            chk($sformatf("t2_r%0d_rr_arready", r), {m0_arready, m1_arready}, (r % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("t2_r%0d_fp_arready", r), {f_m0_arready, f_m1_arready}, 2'b10);
            chk($sformatf("t2_r%0d_busy", r), busy, 0);
            step();
            serve1((r % 2 == 0) ? 4'h1 : 4'h2, 32'hC0DE_0000 + r, r % 2, 0);
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        step();

        // m1 4-beat burst with rready toggling 1,0,1,0
        m1_arid = 4'h7; m1_araddr = 32'h0000_4000; m1_arlen = 4'd3; m1_arsize = 3'd2; m1_arburst = 2'b01;
        m1_arvalid = 1'b1;
        @(negedge aclk);
        chk("t3_m1_arready", m1_arready, 1);
        step();
        m1_arvalid = 1'b0; s_arready = 1'b1;
        @(negedge aclk);
        chk("t3_s_arlen", {s_arvalid, s_arlen}, {1'b1, 4'd3});
        step();
        s_arready = 1'b0;
        beat = 0;
        for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
            m1_rready = (cyc % 2 == 0); m0_rready = 1'b1;
            s_rvalid = 1'b1; s_rdata = 32'hA000 + beat; s_rid = 4'h7; s_rlast = (beat == 3);
            @(negedge aclk);
            chk($sformatf("t3_c%0d_s_rready", cyc), s_rready, m1_rready);
            chk($sformatf("t3_c%0d_m1_beat", cyc), {m1_rvalid, m1_rdata}, {1'b1, 32'hA000 + beat});
            chk($sformatf("t3_c%0d_m0_rvalid", cyc), m0_rvalid, 0);
            chk($sformatf("t3_c%0d_busy", cyc), busy, 1);
            if (m1_rvalid && m1_rready) beat++;
            step();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        chk("t3_beats", beat, 4);
        @(negedge aclk);
        chk("t3_busy_after", busy, 0);
        step();

        // Reset asserted mid-burst on beat 2 of 4, between clock edges
        m0_arid = 4'h3; m0_araddr = 32'h0000_0100; m0_arlen = 4'd3; m0_arvalid = 1'b1;
        step();
        m0_arvalid = 1'b0; s_arready = 1'b1;
        step();
        s_arready = 1'b0; m0_rready = 1'b1; s_rvalid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_rdata = 32'hB000 + b;
            step();
        end
        s_rdata = 32'hB002;
        @(negedge aclk);
        chk("t4_beat2_pending", {m0_rvalid, m0_rdata}, {1'b1, 32'hB002});
        #1 aresetn = 1'b0;
        #1;
        chk("t4_rst_rvalid", {m0_rvalid, m1_rvalid, m0_rdata}, 0);
        chk("t4_rst_ctrl", {s_rready, s_arvalid, busy, m0_arready, m1_arready}, 0);
        chk("t4_rst_held", s_araddr, 0);
        step();
        idle_inputs();
        step();
        aresetn = 1'b1;
        step();
        m0_arid = 4'h9; m0_araddr = 32'h0000_2000; m0_arvalid = 1'b1;
        @(negedge aclk);
        chk("t4_fresh_arready", {m0_arready, m1_arready}, 2'b10);
        step();
        m0_arvalid = 1'b0;
        @(negedge aclk);
        chk("t4_fresh_s_ar", {s_arvalid, s_arid, s_araddr}, {1'b1, 4'h9, 32'h0000_2000});
        step();

        // Randomized traffic against a transaction-level model
        do_reset();
        ph = 0; own = 0; lastw = 1; beats_left = 0; sl_taken = 1'b0; held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m0_arvalid = ($urandom_range(0, 2) != 0); m1_arvalid = ($urandom_range(0, 2) != 0);
            m0_arid = ID_W'($urandom); m0_araddr = $urandom; m0_arlen = 4'($urandom);
            m0_arsize = 3'($urandom); m0_arburst = 2'($urandom);
            m1_arid = ID_W'($urandom); m1_araddr = $urandom; m1_arlen = 4'($urandom);
            m1_arsize = 3'($urandom); m1_arburst = 2'($urandom);
            m0_rready = ($urandom_range(0, 3) != 0); m1_rready = ($urandom_range(0, 3) != 0);
            s_arready = ($urandom_range(0, 2) == 0);
            if (!s_rvalid || sl_taken) begin
                s_rvalid = (beats_left > 0) && ($urandom_range(0, 1) == 1);
                s_rdata = $urandom; s_rresp = 2'($urandom);
                s_rlast = (beats_left == 1);
            end
            @(negedge aclk);
            any = m0_arvalid || m1_arvalid;
            w = (m0_arvalid && m1_arvalid) ? 1 - lastw : (m1_arvalid ? 1 : 0);
            e_srr = (ph == 2) && ((own == 1) ? m1_rready : m0_rready);
            chk("rnd_arready", {m0_arready, m1_arready}, {ph == 0 && any && w == 0, ph == 0 && any && w == 1});
            chk("rnd_s_arvalid", s_arvalid, ph == 1);
            chk("rnd_busy", busy, ph != 0);
            chk("rnd_s_rready", s_rready, e_srr);
            chk("rnd_rvalid", {m0_rvalid, m1_rvalid}, {ph == 2 && own == 0 && s_rvalid, ph == 2 && own == 1 && s_rvalid});
            if (ph == 1) chk("rnd_s_ar", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, held);
            if (ph == 2 && s_rvalid)
                chk("rnd_rbeat", (own == 1) ? {m1_rid, m1_rdata, m1_rresp, m1_rlast} : {m0_rid, m0_rdata, m0_rresp, m0_rlast},
                    {s_rid, s_rdata, s_rresp, s_rlast});
            sl_taken = 1'b0;
            if (ph == 0 && any) begin
                held = (w == 1) ? {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst}
                                : {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst};
                own = w; lastw = w; ph = 1;
            end else if (ph == 1 && s_arready) begin
                ph = 2; beats_left = int'(held.len) + 1; s_rid = held.id;
            end else if (ph == 2 && s_rvalid && e_srr) begin
                sl_taken = 1'b1; beats_left--;
                if (s_rlast) ph = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
